// File: rtl/pr_hrav_dispatcher_issue_pkg.sv
// Shared definitions for the dispatcher read side: FSM encoding and counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pr_hrav_dispatcher_issue_pkg;

  // Issue FSM encoding; values are visible to debug readback, so keep them fixed.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SELECT = 3'd3,
    ST_ISSUE  = 3'd4
  } state_t;

  // Width of the issued-job counter exposed to the control registers.
  localparam int ISSUE_CNT_W = 32;

endpackage

// File: rtl/pr_hrav_dispatcher_rr_pick.sv
// Cyclic priority picker: first set req bit at or after ptr, wrapping at NUM_ENG.
// Latency: combinational.
// Backpressure: none; found=0 when no request is set.
module pr_hrav_dispatcher_rr_pick #(
  parameter int NUM_ENG = 4,
  parameter int ENG_W   = 2
) (
  input  logic [NUM_ENG-1:0] req,
  input  logic [ENG_W-1:0]   ptr,
  output logic               found,
  output logic [ENG_W-1:0]   idx
);

  logic [ENG_W:0] cand;

  // Scan offsets from the far end back to ptr so the closest hit to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_ENG - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (ENG_W + 1)'(k);
      if (cand >= (ENG_W + 1)'(NUM_ENG)) begin
        cand = cand - (ENG_W + 1)'(NUM_ENG);
      end
      if (req[cand[ENG_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[ENG_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pr_hrav_dispatcher_issue.sv
// Pops job words from the dispatcher FIFO and hands each to an idle engine, round-robin.
// Latency: pop strobe 2 cycles after IDLE sees !rempty, engine valid from cycle 4; max 1 job / 5 cycles.
// Backpressure: holds valid/data in ISSUE until the granted engine is ready; waits in SELECT while no engine is idle.
module pr_hrav_dispatcher_issue
  import pr_hrav_dispatcher_issue_pkg::*;
#(
  parameter int DATA_SIZE = 305,
  parameter int NUM_ENG   = 4,
  parameter int ENG_W     = 2
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic                   enable,
  input  logic                   fifo_rempty,
  input  logic [DATA_SIZE-1:0]   fifo_rdata,
  output logic                   fifo_rinc,
  input  logic [NUM_ENG-1:0]     eng_idle,
  input  logic [NUM_ENG-1:0]     eng_ready,
  output logic [NUM_ENG-1:0]     eng_valid,
  output logic [DATA_SIZE-1:0]   eng_data,
  output logic                   busy,
  output logic [ISSUE_CNT_W-1:0] issue_count
);

  state_t               state_q;
  state_t               state_d;
  logic [DATA_SIZE-1:0] data_q;
  logic [ENG_W-1:0]     grant_q;
  logic [ENG_W-1:0]     rr_ptr_q;
  logic                 pick_found;
  logic [ENG_W-1:0]     pick_idx;
  logic                 handshake;

  pr_hrav_dispatcher_rr_pick #(
    .NUM_ENG (NUM_ENG),
    .ENG_W   (ENG_W)
  ) u_rr_pick (
    .req   (eng_idle),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Only the granted engine's ready can complete a transfer.
  assign handshake = (state_q == ST_ISSUE) && eng_ready[grant_q];

  // FSM state register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus state-decoded outputs (pop strobe, one-hot valid, busy).
  always_comb begin
    state_d   = state_q;
    fifo_rinc = 1'b0;
    eng_valid = '0;
    busy      = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_rempty) state_d = ST_WAIT;
      end
      // Bubble so the RAM output reflects the read address moved by the last pop.
      ST_WAIT: state_d = ST_LOAD;
      // Sole consumer, so rempty cannot rise between IDLE and here: pop is always legal.
      ST_LOAD: begin
        fifo_rinc = 1'b1;
        state_d   = ST_SELECT;
      end
      ST_SELECT: begin
        if (pick_found) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        eng_valid[grant_q] = 1'b1;
        if (handshake) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: capture job word, latch grant/output word, advance pointer and counter on handshake.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      data_q      <= '0;
      eng_data    <= '0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      issue_count <= '0;
    end else begin
      if (state_q == ST_LOAD) begin
        data_q <= fifo_rdata;
      end
      if ((state_q == ST_SELECT) && pick_found) begin
        grant_q  <= pick_idx;
        eng_data <= data_q;
      end
      if (handshake) begin
        rr_ptr_q    <= (grant_q == ENG_W'(NUM_ENG - 1)) ? '0 : grant_q + 1'b1;
        issue_count <= issue_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pr_hrav_dispatcher_issue.sv
// Directed bench for the dispatcher issue block: reset, single job, round-robin, skip, stall, gating.
// Latency: checks pop at cycle 2 and valid at cycle 4 relative to IDLE seeing !rempty.
// Backpressure: drives eng_ready low on the granted engine and checks the word holds.
module tb_pr_hrav_dispatcher_issue;

  localparam int DATA_SIZE = 305;
  localparam int NUM_ENG   = 4;
  localparam int ENG_W     = 2;

  logic                 rclk;
  logic                 rrst_n;
  logic                 enable;
  logic                 fifo_rempty;
  logic [DATA_SIZE-1:0] fifo_rdata;
  logic                 fifo_rinc;
  logic [NUM_ENG-1:0]   eng_idle;
  logic [NUM_ENG-1:0]   eng_ready;
  logic [NUM_ENG-1:0]   eng_valid;
  logic [DATA_SIZE-1:0] eng_data;
  logic                 busy;
  logic [31:0]          issue_count;

  int n_checks;
  int n_errors;
  int rinc_total;

  pr_hrav_dispatcher_issue #(
    .DATA_SIZE (DATA_SIZE),
    .NUM_ENG   (NUM_ENG),
    .ENG_W     (ENG_W)
  ) dut (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .enable      (enable),
    .fifo_rempty (fifo_rempty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rinc   (fifo_rinc),
    .eng_idle    (eng_idle),
    .eng_ready   (eng_ready),
    .eng_valid   (eng_valid),
    .eng_data    (eng_data),
    .busy        (busy),
    .issue_count (issue_count)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  // Reset and release; the cycle right after release is IDLE cycle 0.
  task automatic do_reset();
    rrst_n = 1'b0;
    repeat (2) @(posedge rclk);
    #1;
    rrst_n = 1'b1;
  endtask

  // Runs one job from IDLE cycle 0 with engines ready; ends in the next IDLE cycle 0.
  task automatic do_job(input string tag, input logic [NUM_ENG-1:0] exp_vld, input logic [DATA_SIZE-1:0] d);
    int c;
    int rinc_n;
    int rinc_c;
    bit found;
    c      = 0;
    rinc_n = 0;
    rinc_c = -1;
    found  = 1'b0;
    fifo_rdata = d;
    while (c < 20 && !found) begin
      step();
      c++;
      if (fifo_rinc) begin
        rinc_n++;
        rinc_c = c;
      end
      if (eng_valid != '0) found = 1'b1;
    end
    rinc_total += rinc_n;
    chk({tag, "_rinc_pulses"}, rinc_n, 1);
    chk({tag, "_rinc_cycle"}, rinc_c, 2);
    chk({tag, "_valid_cycle"}, c, 4);
    chk({tag, "_valid"}, eng_valid, exp_vld);
    chk({tag, "_data"}, eng_data, d);
    step();
    chk({tag, "_valid_drop"}, eng_valid, '0);
  endtask

  initial begin
    int bad_vld;
    int bad_dat;
    int bad_rinc;
    int bad_busy;
    n_checks    = 0;
    n_errors    = 0;
    rinc_total  = 0;
    rrst_n      = 1'b0;
    enable      = 1'b1;
    fifo_rempty = 1'b0;
    fifo_rdata  = '0;
    eng_idle    = 4'hF;
    eng_ready   = 4'hF;

    // 1. Reset state held with FIFO non-empty and enable high.
    repeat (3) step();
    chk("rst_valid", eng_valid, '0);
    chk("rst_rinc", fifo_rinc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", issue_count, 0);
    chk("rst_data", eng_data, '0);
    rrst_n = 1'b1;
    chk("rel_busy", busy, 0);

    // 2. Single job to engine 0.
    do_job("single", 4'b0001, 305'h1A5);
    chk("single_count", issue_count, 1);

    // 3. Round-robin over five jobs from pointer 0.
    do_reset();
    rinc_total = 0;
    do_job("rr0", 4'b0001, 305'h101);
    do_job("rr1", 4'b0010, 305'h202);
    do_job("rr2", 4'b0100, 305'h303);
    do_job("rr3", 4'b1000, 305'h404);
    do_job("rr4", 4'b0001, 305'h505);
    chk("rr_count", issue_count, 5);
    chk("rr_rinc_total", rinc_total, 5);

    // 4. Skip non-idle engines, then wrap from pointer 3 to engine 0; pointer lands on 1.
    do_reset();
    eng_idle = 4'b0100;
    do_job("skip", 4'b0100, {1'b1, 304'h0, 4'hC} >> 0);
    eng_idle = 4'b0001;
    do_job("wrap", 4'b0001, 305'h0DEAD);
    eng_idle = 4'hF;
    do_job("after_wrap", 4'b0010, 305'h0BEEF);
    chk("skip_count", issue_count, 3);

    // 5. Backpressure on granted engine 2; other readies and idle changes are ignored.
    fifo_rdata = 305'h5A5A_0F0F;
    eng_ready  = 4'b0000;
    repeat (4) step();
    chk("bp_valid", eng_valid, 4'b0100);
    chk("bp_data", eng_data, 305'h5A5A_0F0F);
    fifo_rdata = 305'h1234;
    eng_idle   = 4'b0000;
    eng_ready  = 4'b1011;
    bad_vld  = 0;
    bad_dat  = 0;
    bad_rinc = 0;
    bad_busy = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (eng_valid !== 4'b0100) bad_vld++;
      if (eng_data !== 305'h5A5A_0F0F) bad_dat++;
      if (fifo_rinc !== 1'b0) bad_rinc++;
      if (busy !== 1'b1) bad_busy++;
    end
    chk("bp_hold_valid", bad_vld, 0);
    chk("bp_hold_data", bad_dat, 0);
    chk("bp_no_rinc", bad_rinc, 0);
    chk("bp_busy", bad_busy, 0);
    chk("bp_count_hold", issue_count, 3);
    eng_ready = 4'b0100;
    step();
    chk("bp_done_valid", eng_valid, '0);
    chk("bp_done_count", issue_count, 4);
    chk("bp_data_after", eng_data, 305'h5A5A_0F0F);
    eng_idle  = 4'hF;
    eng_ready = 4'hF;

    // 6a. Gating: no pops while enable is low.
    enable   = 1'b0;
    bad_rinc = 0;
    bad_busy = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fifo_rinc !== 1'b0) bad_rinc++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("gate_rinc", bad_rinc, 0);
    chk("gate_busy", bad_busy, 0);

    // 6b. Reset during ISSUE drops the job asynchronously; pointer was 3 so engine 3 is granted.
    enable     = 1'b1;
    fifo_rdata = 305'h77;
    eng_ready  = 4'b0000;
    repeat (4) step();
    chk("mid_valid", eng_valid, 4'b1000);
    rrst_n = 1'b0;
    #1;
    chk("mid_rst_valid", eng_valid, '0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", issue_count, 0);
    enable = 1'b0;
    step();
    rrst_n = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_data", eng_data, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
